// File: rtl/branch_predict_unit.sv
// Branch resolution against ALU flags plus a PC-indexed 2-bit counter table.
// Ports: clk/rst, lookup_pc->predict_taken, resolve_* + flags -> PCSrc, mispredict, counters.
module branch_predict_unit #(
  parameter int PC_WIDTH  = 32,
  parameter int BHT_DEPTH = 64,
  parameter int INDEX_LSB = 2,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [PC_WIDTH-1:0]  lookup_pc,
  output logic                 predict_taken,
  input  logic                 resolve_valid,
  input  logic [PC_WIDTH-1:0]  resolve_pc,
  input  logic                 resolve_pred,
  input  logic [2:0]           branch,
  input  logic                 zero_flag,
  input  logic                 N_flag,
  input  logic                 V_flag,
  input  logic                 C_flag,
  output logic                 PCSrc,
  output logic                 mispredict,
  output logic [CNT_WIDTH-1:0] branch_count,
  output logic [CNT_WIDTH-1:0] mispredict_count
);

  localparam int IDX_W = $clog2(BHT_DEPTH);

  localparam logic [2:0] BR_NONE = 3'd0;
  localparam logic [2:0] BR_EQ   = 3'd1;
  localparam logic [2:0] BR_NE   = 3'd2;
  localparam logic [2:0] BR_LT   = 3'd3;
  localparam logic [2:0] BR_GE   = 3'd4;
  localparam logic [2:0] BR_LE   = 3'd5;
  localparam logic [2:0] BR_GT   = 3'd6;
  localparam logic [2:0] BR_LTU  = 3'd7;

  localparam logic [1:0] CTR_SN = 2'd0;
  localparam logic [1:0] CTR_WN = 2'd1;
  localparam logic [1:0] CTR_ST = 2'd3;

  logic [IDX_W-1:0] lk_idx;
  logic [IDX_W-1:0] rs_idx;

  assign lk_idx = lookup_pc[INDEX_LSB +: IDX_W];
  assign rs_idx = resolve_pc[INDEX_LSB +: IDX_W];

  // Bits outside the index field are deliberately ignored (aliasing).
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc, resolve_pc};

  logic lt_s;
  logic cond;

  assign lt_s = N_flag ^ V_flag;

  always_comb begin
    cond = 1'b0;
    unique case (branch)
      BR_NONE: cond = 1'b0;
      BR_EQ:   cond = zero_flag;
      BR_NE:   cond = ~zero_flag;
      BR_LT:   cond = lt_s;
      BR_GE:   cond = ~lt_s;
      BR_LE:   cond = lt_s | zero_flag;
      BR_GT:   cond = ~(lt_s | zero_flag);
      BR_LTU:  cond = ~C_flag;
      default: cond = 1'b0;
    endcase
  end

  logic qual;
  logic miss;

  assign PCSrc = resolve_valid & cond;
  assign qual  = resolve_valid & (branch != BR_NONE);
  assign miss  = qual & (PCSrc != resolve_pred);

  logic [1:0] bht_q [BHT_DEPTH];
  logic [1:0] ctr_cur;
  logic [1:0] ctr_d;

  // No bypass: the lookup sees the stored value even when the
  // same entry is being written this cycle.
  assign predict_taken = bht_q[lk_idx][1];
  assign ctr_cur       = bht_q[rs_idx];

  always_comb begin
    ctr_d = ctr_cur;
    if (PCSrc) begin
      if (ctr_cur != CTR_ST) ctr_d = ctr_cur + 2'd1;
    end else begin
      if (ctr_cur != CTR_SN) ctr_d = ctr_cur - 2'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_DEPTH; i++) bht_q[i] <= CTR_WN;
    end else if (qual) begin
      bht_q[rs_idx] <= ctr_d;
    end
  end

  logic                 mp_q;
  logic                 mp_d;
  logic [CNT_WIDTH-1:0] br_cnt_q;
  logic [CNT_WIDTH-1:0] br_cnt_d;
  logic [CNT_WIDTH-1:0] mp_cnt_q;
  logic [CNT_WIDTH-1:0] mp_cnt_d;

  always_comb begin
    mp_d     = miss;
    br_cnt_d = br_cnt_q;
    mp_cnt_d = mp_cnt_q;
    if (qual && !(&br_cnt_q)) br_cnt_d = br_cnt_q + CNT_WIDTH'(1);
    if (miss && !(&mp_cnt_q)) mp_cnt_d = mp_cnt_q + CNT_WIDTH'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mp_q     <= 1'b0;
      br_cnt_q <= '0;
      mp_cnt_q <= '0;
    end else begin
      mp_q     <= mp_d;
      br_cnt_q <= br_cnt_d;
      mp_cnt_q <= mp_cnt_d;
    end
  end

  assign mispredict       = mp_q;
  assign branch_count     = br_cnt_q;
  assign mispredict_count = mp_cnt_q;

endmodule
